// File: rtl/int_sequencer.sv
// Interrupt/reset entry sequencer for the 6502 core: pushes PC and P, sets I, fetches the vector and loads PC.
// Optional NMI_HIJACK_EN: an NMI pending during the pushes of an IRQ/BRK sequence redirects its vector fetch to NMI_VEC.
module int_sequencer #(
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_l,
  input  logic        irq_l,
  input  logic        brk_req,
  input  logic        instr_done,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        brk_ack,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        sp_dec,
  output logic        p_enable,
  output logic        set_carry,
  output logic        set_zero,
  output logic        set_int_disable,
  output logic        set_break,
  output logic        set_overflow,
  output logic        set_negative,
  output logic        pc_load,
  output logic [15:0] pc_out
);

  localparam int unsigned ST_W   = 3;
  localparam int unsigned KIND_W = 2;

  localparam logic [ST_W-1:0] S_RST_HOLD = 3'd0;
  localparam logic [ST_W-1:0] S_IDLE     = 3'd1;
  localparam logic [ST_W-1:0] S_PUSH_PCH = 3'd2;
  localparam logic [ST_W-1:0] S_PUSH_PCL = 3'd3;
  localparam logic [ST_W-1:0] S_PUSH_P   = 3'd4;
  localparam logic [ST_W-1:0] S_VEC_LO   = 3'd5;
  localparam logic [ST_W-1:0] S_VEC_HI   = 3'd6;
  localparam logic [ST_W-1:0] S_LOAD_PC  = 3'd7;

  localparam logic [KIND_W-1:0] K_RESET = 2'd0;
  localparam logic [KIND_W-1:0] K_NMI   = 2'd1;
  localparam logic [KIND_W-1:0] K_IRQ   = 2'd2;
  localparam logic [KIND_W-1:0] K_BRK   = 2'd3;

  logic [ST_W-1:0]   r_state, w_state, w_state_nxt;
  logic [KIND_W-1:0] r_kind, w_kind_nxt;
  logic              r_nmi_q, r_nmi_pend, w_nmi_pend_nxt, w_nmi_edge, w_clr_nmi;
  logic [7:0]        r_vec_lo, w_vec_lo_nxt;
  logic [15:0]       w_vec_base;
  logic              w_unused;

  assign w_unused = p_in[5];

  // State, kind, NMI edge detector and captured vector low byte
  always_ff @(posedge clk) begin
    r_nmi_q <= nmi_l;
    if (reset) begin
      r_state    <= S_RST_HOLD;
      r_kind     <= K_RESET;
      r_nmi_pend <= 1'b0;
      r_vec_lo   <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_kind     <= w_kind_nxt;
      r_nmi_pend <= w_nmi_pend_nxt;
      r_vec_lo   <= w_vec_lo_nxt;
    end
  end

  always_comb begin
    case (r_kind)
      K_NMI:   w_vec_base = NMI_VEC;
      K_RESET: w_vec_base = RST_VEC;
      default: w_vec_base = IRQ_VEC;
    endcase
  end

  // Reset overrides the registered state so an aborted sequence stops driving the bus at once
  always_comb begin
    w_state         = reset ? S_RST_HOLD : r_state;
    w_state_nxt     = w_state;
    w_kind_nxt      = r_kind;
    w_vec_lo_nxt    = r_vec_lo;
    w_nmi_edge      = r_nmi_q & ~nmi_l;
    w_clr_nmi       = 1'b0;
    busy            = (w_state != S_IDLE);
    brk_ack         = 1'b0;
    addr            = 16'h0000;
    data_out        = 8'h00;
    rw              = 1'b1;
    sp_dec          = 1'b0;
    p_enable        = 1'b0;
    set_carry       = p_in[0];
    set_zero        = p_in[1];
    set_int_disable = p_in[2];
    set_break       = p_in[4];
    set_overflow    = p_in[6];
    set_negative    = p_in[7];
    pc_load         = 1'b0;
    pc_out          = 16'h0000;

    case (w_state)
      S_RST_HOLD: begin
        w_state_nxt = S_PUSH_PCH;
        w_kind_nxt  = K_RESET;
      end
      S_IDLE: begin
        if (instr_done) begin
          if (r_nmi_pend) begin
            w_state_nxt = S_PUSH_PCH;
            w_kind_nxt  = K_NMI;
          end else if (brk_req) begin
            w_state_nxt = S_PUSH_PCH;
            w_kind_nxt  = K_BRK;
            brk_ack     = 1'b1;
          end else if (~irq_l & ~p_in[2]) begin
            w_state_nxt = S_PUSH_PCH;
            w_kind_nxt  = K_IRQ;
          end
        end
      end
      S_PUSH_PCH: begin
        addr        = {STACK_PAGE, sp_in};
        data_out    = pc_in[15:8];
        rw          = (r_kind == K_RESET);
        sp_dec      = 1'b1;
        w_state_nxt = S_PUSH_PCL;
      end
      S_PUSH_PCL: begin
        addr        = {STACK_PAGE, sp_in};
        data_out    = pc_in[7:0];
        rw          = (r_kind == K_RESET);
        sp_dec      = 1'b1;
        w_state_nxt = S_PUSH_P;
      end
      S_PUSH_P: begin
        addr        = {STACK_PAGE, sp_in};
        data_out    = {p_in[7:6], 1'b1, (r_kind == K_BRK), p_in[3:0]};
        rw          = (r_kind == K_RESET);
        sp_dec      = 1'b1;
        w_state_nxt = S_VEC_LO;
`ifdef NMI_HIJACK_EN
        if (r_nmi_pend && ((r_kind == K_IRQ) || (r_kind == K_BRK)))
          w_kind_nxt = K_NMI;
`endif
        w_clr_nmi = (w_kind_nxt == K_NMI);
      end
      S_VEC_LO: begin
        addr            = w_vec_base;
        p_enable        = 1'b1;
        set_int_disable = 1'b1;
        w_state_nxt     = S_VEC_HI;
      end
      S_VEC_HI: begin
        addr         = w_vec_base + 16'd1;
        w_vec_lo_nxt = data_in;
        w_state_nxt  = S_LOAD_PC;
      end
      S_LOAD_PC: begin
        pc_out      = {data_in, r_vec_lo};
        pc_load     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_RST_HOLD;
    endcase

    // A new edge in the clearing cycle keeps the NMI pending
    w_nmi_pend_nxt = w_nmi_edge | (r_nmi_pend & ~w_clr_nmi);
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Interrupt/reset sequencer for the 6502 core.
- On RESET, NMI, IRQ or BRK it stalls the core, pushes PCH, PCL and P to the stack, and sets the I flag through the processor status register's load port.
- It then fetches the 16-bit vector and loads PC.
- Sits between the decoder/instruction-boundary logic, the stack pointer, the memory bus and the P register.

Parameters:
- NMI_VEC, 16'hFFFA, NMI vector low-byte address
- RST_VEC, 16'hFFFC, reset vector low-byte address
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address
- STACK_PAGE, 8'h01, high byte of stack addresses

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- nmi_l  in  1  NMI line, active low, edge-triggered
- irq_l  in  1  IRQ line, active low, level
- brk_req  in  1  decoder has fetched a BRK opcode
- instr_done  in  1  instruction boundary pulse
- pc_in  in  16  current PC, already advanced past BRK padding if applicable
- sp_in  in  8  current stack pointer
- p_in  in  8  current status {N,V,-,B,D,I,Z,C}
- data_in  in  8  memory read data, valid one cycle after address
- busy  out  1  sequence active; core stalls
- brk_ack  out  1  one-cycle pulse when a BRK sequence is accepted
- addr  out  16  bus address
- data_out  out  8  bus write data
- rw  out  1  1 = read, 0 = write
- sp_dec  out  1  decrement SP this cycle
- p_enable  out  1  load P register this cycle
- set_carry, set_zero, set_int_disable, set_break, set_overflow, set_negative  out  1 each  P register load values
- pc_load  out  1  load PC from pc_out
- pc_out  out  16  assembled vector

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on port reset; the polarity and synchronicity are fixed.
- While reset is high:
  - state = RST_HOLD, nmi_pend = 0, kind = RESET.
  - busy = 1; all other outputs 0, except rw = 1 and set_* = mirrored p_in.
- Reset asserted mid-sequence aborts that sequence immediately; no partial PC load.
- First cycle after reset deasserts: go to PUSH_PCH with kind = RESET.
- NMI detect:
  - nmi_l is registered once; a 1->0 transition between consecutive samples sets nmi_pend.
  - nmi_pend clears on entry to VEC_LO with kind = NMI.
  - An edge arriving in that same cycle re-sets nmi_pend (set wins).
- Acceptance, IDLE only, at cycles with instr_done = 1. Priority:
  1. nmi_pend -> NMI
  2. brk_req -> BRK; pulse brk_ack
  3. ~irq_l & ~p_in[2] -> IRQ
- An IRQ masked by I is never taken. A level IRQ still low after return is retaken at the next boundary.
- An NMI beating BRK drops the BRK without brk_ack; the decoder reissues it.
- States; one per cycle, busy = 1 in all except IDLE:
  - PUSH_PCH: addr = {STACK_PAGE, sp_in}, data_out = pc_in[15:8], sp_dec = 1.
  - PUSH_PCL: same addressing, data_out = pc_in[7:0], sp_dec = 1.
  - PUSH_P: same addressing, data_out = {p_in[7:6], 1'b1, B, p_in[3:0]}, with B = 1 for BRK and 0 otherwise; sp_dec = 1.
  - Push writes: rw = 0 for NMI/IRQ/BRK. For RESET, rw = 1 (suppressed writes), but sp_dec still pulses.
  - VEC_LO: addr = vector base (NMI_VEC, RST_VEC, IRQ_VEC by kind; BRK uses IRQ_VEC); rw = 1. Also p_enable = 1, set_int_disable = 1, other set_* = corresponding p_in bits.
  - VEC_HI: addr = base + 1, rw = 1; capture data_in as vector low byte.
  - LOAD_PC: pc_out = {data_in, low}, pc_load = 1, rw = 1, addr = 0 -> IDLE.
- Outside VEC_LO: p_enable = 0, set_* mirror p_in.
- Outside sequences: rw = 1, sp_dec = 0, pc_load = 0.
- Latency: acceptance cycle N -> PUSH_PCH at N+1 -> pc_load at N+6.
- SP wraps naturally: sp_in = 8'h00 pushes to 16'h0100; wrap is handled by the SP owner.

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined: if nmi_pend becomes set during PUSH_PCH, PUSH_PCL or PUSH_P of an IRQ or BRK sequence, the vector fetch uses NMI_VEC and clears nmi_pend. The already-computed B bit in the pushed P is kept.
- Undefined: kind is fixed at acceptance; the NMI waits for the next boundary.

Test Plan:
- Reset held 3 cycles then released, sp_in = 8'hFD, memory FFFC/FFFD = 34/12 -> three sp_dec pulses with rw = 1 throughout, p_enable with set_int_disable = 1, pc_load with pc_out = 16'h1234 six cycles after release.
- IRQ low, p_in = 8'h00, instr_done, pc_in = 16'hC123, sp_in = 8'hFF -> writes C1 @01FF, 23 @01FF (SP held externally), 20 @01FF, then vector read at FFFE.
- BRK with p_in = 8'h81 -> brk_ack pulse, pushed P = 8'hB1, vector IRQ_VEC.
- irq_l low with p_in[2] = 1 across 3 boundaries -> busy stays 0.
- NMI falling edge and IRQ at the same boundary -> NMI sequence (vector FFFA, pushed B = 0); IRQ taken at the next boundary after return.
- Reset asserted during PUSH_PCL -> no pc_load from the aborted sequence; restart behaves as the first reset test. With NMI_HIJACK_EN: NMI edge during PUSH_PCH of an IRQ sequence -> vector read at FFFA.
